// File: rtl/spi_debug_master.sv
// spi_debug_master
// ----------------
// SPI mode-0 master for the pipeline debug bus. It runs one full-duplex
// NB_BITS word, MSB first, to one stage slave per request. The debug
// controller sees a simple start/done interface.
//
// Ports
//   i_clk      system clock
//   i_rst      synchronous reset, active low
//   i_start    transfer request, only looked at while idle
//   i_cs_sel   slave index, captured together with i_start
//   i_tx_data  word to send, captured together with i_start
//   i_MISO     serial return data from the selected slave
//   o_rx_data  last received word, updated in the DONE cycle
//   o_done     one-cycle end-of-transfer pulse
//   o_busy     high while a transfer is in progress
//   o_SCLK     serial clock, idles low
//   o_MOSI     serial data to the slaves
//   o_SPI_cs   active-low chip selects, idle all ones
module spi_debug_master #(
    parameter int NB_BITS  = 32,
    parameter int NB_CS    = 4,
    parameter int NB_SEL   = 2,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_SEL-1:0]  i_cs_sel,
    input  logic [NB_BITS-1:0] i_tx_data,
    input  logic               i_MISO,
    output logic [NB_BITS-1:0] o_rx_data,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_SCLK,
    output logic               o_MOSI,
    output logic [NB_CS-1:0]   o_SPI_cs
);

    localparam int CNT_W = 16;
    localparam int BIT_W = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NB_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;      // cycles spent in the current phase
    logic [BIT_W-1:0]   bit_q;      // index of the bit being transferred
    logic [NB_BITS-1:0] tx_q;       // tx_q[NB_BITS-1] is the bit on MOSI
    logic [NB_BITS-1:0] rx_q;
    logic [NB_BITS-1:0] rx_data_q;
    logic               done_q;
    logic               busy_q;
    logic               sclk_q;     // doubles as the XFER half-period phase
    logic               mosi_q;
    logic [NB_CS-1:0]   cs_q;       // holds the captured slave select

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        tx_q    <= i_tx_data;
                        mosi_q  <= i_tx_data[NB_BITS-1];
                        cs_q    <= ~(NB_CS'(1) << i_cs_sel);
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_XFER;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_XFER: begin
                    if (cnt_q != DIV_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (!sclk_q) begin
                        // end of low phase: rising edge, slave samples MOSI
                        cnt_q  <= '0;
                        sclk_q <= 1'b1;
                    end else begin
                        // End of high phase: falling edge. MISO has been
                        // stable for a full half-period here, so it is
                        // captured now, and MOSI moves to the next bit.
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        rx_q   <= {rx_q[NB_BITS-2:0], i_MISO};
                        tx_q   <= {tx_q[NB_BITS-2:0], 1'b0};
                        if (bit_q == BIT_LAST) begin
                            mosi_q  <= 1'b0;
                            state_q <= ST_HOLD;
                        end else begin
                            mosi_q <= tx_q[NB_BITS-2];
                            bit_q  <= bit_q + 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q     <= '0;
                        cs_q      <= '1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_q;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rx_data = rx_data_q;
    assign o_done    = done_q;
    assign o_busy    = busy_q;
    assign o_SCLK    = sclk_q;
    assign o_MOSI    = mosi_q;
    assign o_SPI_cs  = cs_q;

endmodule

// File: tb/tb_spi_debug_master.sv
// tb_spi_debug_master
// -------------------
// Directed checks of spi_debug_master. dut_a uses the default timing.
// dut_b uses the fastest timing (CLK_DIV=1, CS_SETUP=1, CS_HOLD=1).
// Only the DUT picked by use_b receives i_start, and its outputs are
// routed to the shared observation signals used by the tasks.
module tb_spi_debug_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  sel = '0;
    logic [31:0] tx = '0;
    int          miso_mode = 2;   // 0: tie low, 1: tie high, 2: loopback
    logic        use_b = 1'b0;

    logic [31:0] rx_a, rx_b;
    logic        done_a, done_b, busy_a, busy_b, sclk_a, sclk_b, mosi_a, mosi_b;
    logic [3:0]  cs_a, cs_b;
    logic        miso_a, miso_b, start_a, start_b;

    logic [31:0] ob_rx;
    logic        ob_done, ob_busy, ob_sclk, ob_mosi;
    logic [3:0]  ob_cs;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start_a = start & ~use_b;
    assign start_b = start & use_b;
    assign miso_a  = (miso_mode == 2) ? mosi_a : (miso_mode == 1);
    assign miso_b  = (miso_mode == 2) ? mosi_b : (miso_mode == 1);

    assign ob_rx   = use_b ? rx_b   : rx_a;
    assign ob_done = use_b ? done_b : done_a;
    assign ob_busy = use_b ? busy_b : busy_a;
    assign ob_sclk = use_b ? sclk_b : sclk_a;
    assign ob_mosi = use_b ? mosi_b : mosi_a;
    assign ob_cs   = use_b ? cs_b   : cs_a;

    spi_debug_master dut_a (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start_a),
        .i_cs_sel  (sel),
        .i_tx_data (tx),
        .i_MISO    (miso_a),
        .o_rx_data (rx_a),
        .o_done    (done_a),
        .o_busy    (busy_a),
        .o_SCLK    (sclk_a),
        .o_MOSI    (mosi_a),
        .o_SPI_cs  (cs_a)
    );

    spi_debug_master #(
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_HOLD  (1)
    ) dut_b (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start_b),
        .i_cs_sel  (sel),
        .i_tx_data (tx),
        .i_MISO    (miso_b),
        .o_rx_data (rx_b),
        .o_done    (done_b),
        .o_busy    (busy_b),
        .o_SCLK    (sclk_b),
        .o_MOSI    (mosi_b),
        .o_SPI_cs  (cs_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Raise i_start during the current cycle k. The DUT samples it at the
    // end of cycle k.
    task automatic start_xfer(input logic [1:0] s, input logic [31:0] d, output int k);
        @(posedge clk);
        #1;
        start = 1'b1;
        sel   = s;
        tx    = d;
        k     = cyc;
    endtask

    // Follow one transfer whose i_start was sampled at the end of cycle k.
    // The task checks:
    //   - busy offset and done offset;
    //   - the SCLK rising-edge count;
    //   - the high and low half-period lengths;
    //   - the chip selects for as long as busy is high.
    // With poke set, a stray start with sel=0 and tx=0 is pulsed mid-transfer.
    task automatic wait_done(input int k, input int lat, input int div,
                             input logic [3:0] exp_cs, input bit poke, input bit hold,
                             output logic [31:0] rx, output logic [31:0] mbits,
                             output int done_cyc);
        int   rises = 0;
        int   busy_first = -1;
        int   run = 0;
        int   bad_run = 0;
        int   cs_bad = 0;
        logic prev_sc = 1'b0;
        logic sc;
        mbits    = '0;
        rx       = '0;
        done_cyc = -1;
        for (int n = 0; n < lat + 20 && done_cyc < 0; n++) begin
            @(posedge clk);
            #1;
            if (!hold && cyc >= k + 1) start = 1'b0;
            if (poke && cyc == k + 100) begin
                start = 1'b1;
                sel   = 2'd0;
                tx    = 32'h0;
            end
            if (poke && cyc == k + 101) start = 1'b0;
            if (ob_busy && busy_first < 0) busy_first = cyc;
            if (ob_busy && ob_cs !== exp_cs) cs_bad++;
            sc = ob_sclk;
            if (sc == prev_sc) begin
                run++;
            end else begin
                if (prev_sc && run != div) bad_run++;
                if (!prev_sc && rises > 0 && run != div) bad_run++;
                run = 1;
            end
            if (!prev_sc && sc) begin
                rises++;
                mbits = {mbits[30:0], ob_mosi};
            end
            prev_sc = sc;
            if (ob_done) begin
                done_cyc = cyc;
                rx       = ob_rx;
            end
        end
        chk("busy_offset", 64'(busy_first - k), 64'd1);
        chk("done_offset", 64'(done_cyc - k), 64'(lat));
        chk("sclk_rises", 64'(rises), 64'd32);
        chk("sclk_halfperiod", 64'(bad_run), 64'd0);
        chk("cs_during_xfer", 64'(cs_bad), 64'd0);
        chk("cs_at_done", 64'(ob_cs), 64'hF);
        chk("busy_at_done", 64'(ob_busy), 64'd0);
        $display("xfer k=%0d done_at=+%0d cs=%b rises=%0d rx=%h", k, done_cyc - k, exp_cs, rises, rx);
    endtask

    initial begin
        int          k;
        int          dc;
        int          rises;
        int          spurious;
        logic [31:0] rx;
        logic [31:0] mb;
        logic        prev_sc;
        logic [1:0]  sweep [3];

        sweep[0] = 2'd0;
        sweep[1] = 2'd1;
        sweep[2] = 2'd3;

        // 1: reset held for three cycles with random inputs
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            start     = 1'($urandom);
            sel       = 2'($urandom);
            tx        = $urandom;
            miso_mode = int'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        chk("rst_cs", 64'(cs_a), 64'hF);
        chk("rst_sclk", 64'(sclk_a), 64'd0);
        chk("rst_mosi", 64'(mosi_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_rx", 64'(rx_a), 64'd0);
        start = 1'b0;
        rst   = 1'b1;
        miso_mode = 2;
        @(posedge clk);

        // 2: loopback DEADBEEF to slave 2, then check that done is a single pulse
        start_xfer(2'd2, 32'hDEADBEEF, k);
        wait_done(k, 261, 4, 4'b1011, 1'b0, 1'b0, rx, mb, dc);
        chk("loop_deadbeef", 64'(rx), 64'hDEADBEEF);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(done_a), 64'd0);
        chk("rx_held", 64'(rx_a), 64'hDEADBEEF);

        // 3: bit order on MOSI, with MISO tied high and then tied low
        miso_mode = 1;
        start_xfer(2'd1, 32'h80000001, k);
        wait_done(k, 261, 4, 4'b1101, 1'b0, 1'b0, rx, mb, dc);
        chk("mosi_bits", 64'(mb), 64'h80000001);
        chk("miso_ones", 64'(rx), 64'hFFFFFFFF);
        miso_mode = 0;
        start_xfer(2'd1, 32'h80000001, k);
        wait_done(k, 261, 4, 4'b1101, 1'b0, 1'b0, rx, mb, dc);
        chk("miso_zeros", 64'(rx), 64'h0);

        // 4a: a stray start mid-transfer (sel=0, tx=0) must be ignored
        miso_mode = 2;
        start_xfer(2'd1, 32'hA5C30F96, k);
        wait_done(k, 261, 4, 4'b1101, 1'b1, 1'b0, rx, mb, dc);
        chk("poke_ignored", 64'(rx), 64'hA5C30F96);

        // 4b: start held through DONE gives a second transfer from IDLE
        start_xfer(2'd3, 32'h13579BDF, k);
        wait_done(k, 261, 4, 4'b0111, 1'b0, 1'b1, rx, mb, dc);
        chk("held_first", 64'(rx), 64'h13579BDF);
        wait_done(dc + 1, 261, 4, 4'b0111, 1'b0, 1'b0, rx, mb, dc);
        chk("held_second", 64'(rx), 64'h13579BDF);

        // 5: reset after the 10th SCLK rising edge aborts the transfer
        start_xfer(2'd1, 32'hFFFF0000, k);
        rises   = 0;
        prev_sc = 1'b0;
        for (int n = 0; n < 400 && rises < 10; n++) begin
            @(posedge clk);
            #1;
            if (cyc >= k + 1) start = 1'b0;
            if (!prev_sc && sclk_a) rises++;
            prev_sc = sclk_a;
        end
        chk("abort_rises", 64'(rises), 64'd10);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cs", 64'(cs_a), 64'hF);
        chk("abort_sclk", 64'(sclk_a), 64'd0);
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_mosi", 64'(mosi_a), 64'd0);
        chk("abort_rx", 64'(rx_a), 64'd0);
        rst = 1'b1;
        spurious = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (done_a || busy_a) spurious++;
        end
        chk("abort_no_done", 64'(spurious), 64'd0);
        start_xfer(2'd0, 32'h12345678, k);
        wait_done(k, 261, 4, 4'b1110, 1'b0, 1'b0, rx, mb, dc);
        chk("after_abort", 64'(rx), 64'h12345678);

        // 6: fast timing instance, sweep of slave selects
        use_b = 1'b1;
        foreach (sweep[i]) begin
            start_xfer(sweep[i], 32'hC0FFEE00 + 32'(sweep[i]), k);
            wait_done(k, 67, 1, ~(4'b0001 << sweep[i]), 1'b0, 1'b0, rx, mb, dc);
            chk("fast_loop", 64'(rx), 64'(32'hC0FFEE00 + 32'(sweep[i])));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_debug_master.md
Name: spi_debug_master

Overview:
SPI master that drives the shared debug SPI bus of the Mips pipeline: o_SCLK, o_MOSI and per-stage chip selects o_SPI_cs. It samples the shared o_MISO return line on its i_MISO input. Each transaction is one full-duplex NB_BITS word to one selected stage slave (0=Fetch, 1=Decode, 2=Execution, 3=Mem). It sits on the debugger side of the bus (host-bridge logic) and gives a simple start/done word interface to the debug controller.

Parameters:
NB_BITS, 32, transfer word width
NB_CS, 4, number of chip-select lines
NB_SEL, 2, width of the slave-select index
CLK_DIV, 4, i_clk cycles per SCLK half-period (must be >= 1)
CS_SETUP, 2, i_clk cycles from CS assert to first SCLK rising edge (must be >= 1)
CS_HOLD, 2, i_clk cycles from last SCLK falling edge to CS deassert (must be >= 1)

Ports:
i_clk  in  1  system clock, single clock domain
i_rst  in  1  synchronous reset, active-low
i_start  in  1  request transfer; sampled only in IDLE
i_cs_sel  in  NB_SEL  slave index, latched with i_start
i_tx_data  in  NB_BITS  word to send, latched with i_start
i_MISO  in  1  serial data from the selected slave
o_rx_data  out  NB_BITS  last received word, valid from o_done onward
o_done  out  1  one-cycle pulse at end of transfer
o_busy  out  1  transfer in progress
o_SCLK  out  1  serial clock, idle low (CPOL=0)
o_MOSI  out  1  serial data to slaves, MSB first
o_SPI_cs  out  NB_CS  chip selects, active-low, idle all ones

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (i_rst==0 at a rising edge) forces:
  - o_SPI_cs all ones, o_SCLK=0, o_MOSI=0
  - o_busy=0, o_done=0, o_rx_data=0
  - state IDLE; all counters and shift registers cleared
- Reset has priority over every other event, including mid-transfer. No o_done is produced for an aborted transfer.
- FSM states: IDLE, SETUP, XFER, HOLD, DONE.
- IDLE:
  - If i_start=1: latch i_tx_data into the tx shift register and latch i_cs_sel.
  - Go to SETUP and drive o_SPI_cs[i_cs_sel]=0 (the other bits stay 1).
  - Drive o_MOSI = i_tx_data[NB_BITS-1] and set o_busy=1.
- SETUP: hold for CS_SETUP cycles with o_SCLK=0, then go to XFER.
- XFER, one bit per 2*CLK_DIV cycles:
  - o_SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - At the edge ending each high phase, SCLK returns low and i_MISO is shifted into the LSB of the rx shift register (MSB first overall).
  - At that same edge, o_MOSI advances to the next tx bit.
  - After the NB_BITS-th high phase, o_MOSI=0 and the FSM goes to HOLD.
  - Exactly NB_BITS SCLK rising edges occur per transfer.
- HOLD: CS_HOLD cycles with CS still asserted and o_SCLK=0, then go to DONE.
- DONE (one cycle):
  - o_SPI_cs all ones, o_busy=0, o_done=1.
  - o_rx_data is loaded with the rx shift register and held until the next DONE or reset.
  - Next state is IDLE.
- i_start is ignored in SETUP, XFER, HOLD and DONE. An i_start held high continuously produces back-to-back transfers, each starting from IDLE.
- Latency, with i_start sampled at edge k:
  - o_busy rises at k+1.
  - o_done is high in cycle k+1+CS_SETUP+2*CLK_DIV*NB_BITS+CS_HOLD. With defaults that is k+261.
- i_tx_data and i_cs_sel changing during a transfer have no effect.
- Mode 0 timing with MISO sampled at the end of the high phase gives synchronous slaves a full half-period of margin.

Test Plan:
1. Hold i_rst=0 for 3 cycles with random inputs -> o_SPI_cs=4'b1111, o_SCLK=0, o_MOSI=0, o_busy=0, o_done=0, o_rx_data=0.
2. Loopback o_MOSI->i_MISO, start with tx=32'hDEADBEEF, sel=2 -> o_SPI_cs=4'b1011 for the whole transfer, 32 SCLK rising edges, o_done at k+261, o_rx_data=32'hDEADBEEF.
3. tx=32'h80000001, i_MISO tied 1 -> o_MOSI is 1,0×30,1 on successive rising edges, SCLK high and low each exactly 4 cycles, o_rx_data=32'hFFFFFFFF. Repeat with i_MISO tied 0 -> o_rx_data=0.
4. Pulse i_start during XFER with sel=0 -> ignored, cs and data unchanged. Hold i_start=1 through DONE -> a new transfer starts with o_busy rising one cycle after the IDLE following DONE.
5. Assert i_rst=0 after 10 rising SCLK edges -> next edge o_SPI_cs=4'b1111, o_SCLK=0, o_busy=0, no o_done. A following transfer with tx=32'h12345678 in loopback returns 32'h12345678.
6. Sweep sel=0,1,3 with CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 -> only the selected cs bit goes low, o_done at k+67, loopback data correct.
